row_window_feeder: RTL and testbench
====================================

# row_window_feeder

Converts a raster pixel stream (one 8-bit pixel per accepted cycle, row-major) into the three-row parallel window consumed by `minHardware` (`in1`/`in2`/`in3`, `WIDTH` pixels each). It sits between the frame source (file reader or camera front end) and `minHardware`. It replaces the bench-side row-shifting loop with synthesizable buffering, and emits exactly `HEIGHT` windows per frame with vertical border padding.

## Interface

Parameters:
- `WIDTH`, 320: pixels per row.
- `HEIGHT`, 240: rows per frame.
- `PIXEL_W`, 8: bits per pixel.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `pix_in`  in  `PIXEL_W`: incoming pixel.
- `pix_valid`  in  1: `pix_in` valid.
- `pix_sof`  in  1: qualifies `pix_in` as pixel (0,0) of a new frame.
- `pix_ready`  out  1: block can accept a pixel this cycle.
- `row_top`  out  `WIDTH*PIXEL_W`: row c-1 (drives `in1`); pixel x at bits [x*PIXEL_W +: PIXEL_W].
- `row_mid`  out  `WIDTH*PIXEL_W`: row c (drives `in2`).
- `row_bot`  out  `WIDTH*PIXEL_W`: row c+1 (drives `in3`).
- `row_valid`  out  1: one-cycle pulse; the window is new this cycle.
- `row_index`  out  `$clog2(HEIGHT)`: center row c of the current window.
- `frame_done`  out  1: one-cycle pulse coincident with the window for c = `HEIGHT`-1.

## Operation

- A pixel is accepted when `pix_valid && pix_ready`.
- Accepted pixels are written to the line accumulator `acc[x]`.
- Column counter `x` runs 0..`WIDTH`-1. Row counter `y` runs 0..`HEIGHT`-1.
- Row completion is acceptance at x = `WIDTH`-1. The completed row R is `acc` with the final pixel merged in.
- On completion, the window shifts: top<=mid, mid<=bot, bot<=R.
- Row-0 completion: top<=PAD, mid<=PAD, bot<=R. No `row_valid` is emitted.
- Rows y >= 1 completion: shift, then pulse `row_valid` with `row_index` = y-1.
- FSM states:
  - FILL: `pix_ready`=1.
  - FLUSH: `pix_ready`=0.
- FILL->FLUSH on completion of row `HEIGHT`-1.
- FLUSH lasts one cycle:
  - Shift with bot<=PAD.
  - Pulse `row_valid` with `row_index`=`HEIGHT`-1, plus `frame_done`.
  - Clear `x` and `y`, then return to FILL.
- PAD is all-zero. See Configuration for the alternative.
- `pix_sof` is accepted with a pixel while (x,y) != (0,0): resync.
  - Counters restart with that pixel as (0,0).
  - Window registers clear to 0.
  - The partial frame emits nothing further.
- `pix_sof` at (0,0) is normal. `pix_sof` is optional at (0,0).
- Window outputs hold their value between updates.
- Counter wrap: x wraps to 0 and y increments at row end. y never exceeds `HEIGHT`-1.

## Timing

- Reset values: all row buses 0; `row_valid` 0; `frame_done` 0; `row_index` 0; state FILL, so `pix_ready`=1; x=y=0.
- Reset asserted mid-frame aborts immediately. No pending window is emitted after release.
- `pix_ready` is combinational from state.
- All other outputs are registered.
- Latency, normal row: the last pixel of row y is accepted at edge E. At E, the window registers update and `row_valid`=1 for the cycle after E.
- Latency, end of frame:
  - Last pixel of row `HEIGHT`-1 accepted at edge E0: window c=`HEIGHT`-2 is valid after E0, and `pix_ready`=0 in that cycle.
  - At E1: window c=`HEIGHT`-1 is valid with `frame_done`=1. `pix_ready` returns to 1.
- `pix_valid` gaps are allowed anywhere. Counters advance only on acceptance.
- `row_valid` is never asserted on consecutive cycles, except E0/E1 at frame end.
- Consumer has no backpressure. It must sample on `row_valid`.

## Configuration

- `ROW_EDGE_REPLICATE_EN` defined: PAD replicates the edge row.
  - Row-0 completion sets top<=R and mid<=R, so window 0 has top = row 0.
  - FLUSH sets bot<=mid, so the last window has bot = row `HEIGHT`-1.
  - Resync still clears to 0.
- Undefined: zero padding as described above.

## Test plan

- Reset/idle, WIDTH=4, HEIGHT=3: hold `rst_n`=0, then release. Required: `pix_ready`=1, all buses 0, no `row_valid` for 10 idle cycles.
- Full frame, WIDTH=4, HEIGHT=3, pixel = 16*y+x, continuous valid with `pix_sof` on the first pixel. Required:
  - Window 0 (after pixel 8): top=0, mid={03,02,01,00}, bot={13,12,11,10}.
  - Window 1 (after pixel 12): `row_index`=1.
  - Window 2 one cycle later: bot=0, `frame_done`=1.
  - `pix_ready`=0 for exactly one cycle.
- Gapped input: same frame with `pix_valid` toggling 1/0. Required: identical window contents; `row_valid` only after row-completing acceptances.
- Resync: assert `pix_sof` at (2,1) mid-frame. Required: windows clear to 0; the next full frame produces the correct 3 windows.
- Reset mid-frame: pull `rst_n` low at (1,2). Required: outputs at reset values immediately; no `row_valid` after release until a new row 1 completes.
- Replicate build, `ROW_EDGE_REPLICATE_EN` defined, same frame as above. Required:
  - Window 0: top={03,02,01,00}.
  - Window 2: bot={23,22,21,20}.

Source files
------------

// File: rtl/row_window_feeder.sv
// Raster-to-window converter: buffers a pixel stream into a three-row window (top/mid/bot) with vertical padding.
// Define ROW_EDGE_REPLICATE_EN to pad by replicating the edge row instead of zero padding.
module row_window_feeder #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int PIXEL_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIXEL_W-1:0]         pix_in,
  input  logic                       pix_valid,
  input  logic                       pix_sof,
  output logic                       pix_ready,
  output logic [WIDTH*PIXEL_W-1:0]   row_top,
  output logic [WIDTH*PIXEL_W-1:0]   row_mid,
  output logic [WIDTH*PIXEL_W-1:0]   row_bot,
  output logic                       row_valid,
  output logic [$clog2(HEIGHT)-1:0]  row_index,
  output logic                       frame_done
);

  localparam int XW    = $clog2(WIDTH);
  localparam int IW    = $clog2(HEIGHT);
  localparam int BUS_W = WIDTH * PIXEL_W;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [IW-1:0] Y_LAST = IW'(HEIGHT - 1);

  typedef enum logic {FILL, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [IW-1:0]          y_q, y_d;
  logic [BUS_W-1:0]       top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic                   valid_q, valid_d, done_q, done_d;
  logic [IW-1:0]          index_q, index_d;
  logic [BUS_W-PIXEL_W-1:0] acc_q;
  logic [BUS_W-1:0]       row_r, pad_top, pad_bot;
  logic                   accept, resync, row_end;

  assign accept  = pix_valid && pix_ready;
  assign resync  = accept && pix_sof && ((x_q != '0) || (y_q != '0));
  assign row_end = accept && !resync && (x_q == X_LAST);
  // The last pixel of a row never lands in the accumulator; it is merged on the fly.
  assign row_r   = {pix_in, acc_q};

`ifdef ROW_EDGE_REPLICATE_EN
  assign pad_top = row_r;
  assign pad_bot = bot_q;
`else
  assign pad_top = '0;
  assign pad_bot = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      FILL:    if (row_end && (y_q == Y_LAST)) state_d = FLUSH;
      FLUSH:   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == FILL);
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    index_d = index_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (state_q == FLUSH) begin
      top_d   = mid_q;
      mid_d   = bot_q;
      bot_d   = pad_bot;
      valid_d = 1'b1;
      done_d  = 1'b1;
      index_d = Y_LAST;
      x_d     = '0;
      y_d     = '0;
    end else if (resync) begin
      // The sof pixel becomes (0,0); the partial frame is abandoned.
      x_d   = XW'(1);
      y_d   = '0;
      top_d = '0;
      mid_d = '0;
      bot_d = '0;
    end else if (row_end) begin
      x_d = '0;
      if (y_q == '0) begin
        top_d = pad_top;
        mid_d = pad_top;
        bot_d = row_r;
      end else begin
        top_d   = mid_q;
        mid_d   = bot_q;
        bot_d   = row_r;
        valid_d = 1'b1;
        index_d = y_q - IW'(1);
      end
      if (y_q != Y_LAST) y_d = y_q + IW'(1);
    end else if (accept) begin
      x_d = x_q + XW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      index_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      index_q <= index_d;
    end
  end

  // NOTE: the line accumulator has no reset; every slot is rewritten before a row completes.
  always_ff @(posedge clk) begin
    if (accept && (resync || (x_q != X_LAST))) begin
      acc_q[(resync ? 0 : int'(x_q)) * PIXEL_W +: PIXEL_W] <= pix_in;
    end
  end

  assign row_top    = top_q;
  assign row_mid    = mid_q;
  assign row_bot    = bot_q;
  assign row_valid  = valid_q;
  assign row_index  = index_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_row_window_feeder.sv
// Scoreboard bench for row_window_feeder: a frame-level model predicts each window, a negedge monitor compares.
// Build with ROW_EDGE_REPLICATE_EN defined to exercise the edge-replicate padding in both DUT and model.
module tb_row_window_feeder;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int PW  = 8;
  localparam int BUS = W * PW;
  localparam int IW  = $clog2(H);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PW-1:0]  pix_in;
  logic           pix_valid;
  logic           pix_sof;
  logic           pix_ready;
  logic [BUS-1:0] row_top, row_mid, row_bot;
  logic           row_valid;
  logic [IW-1:0]  row_index;
  logic           frame_done;

  row_window_feeder #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .row_valid(row_valid), .row_index(row_index), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS-1:0] top, mid, bot;
    int             idx;
    bit             fd;
    bit             rdy;
    int             due;
  } win_t;

  win_t          sb[$];
  win_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            ncyc     = 0;
  logic [PW-1:0] rows [H][W];
  int            mx = 0;
  int            my = 0;

  task automatic check(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BUS-1:0] row_vec(input int r);
    logic [BUS-1:0] v;
    for (int x = 0; x < W; x++) v[x*PW +: PW] = rows[r][x];
    return v;
  endfunction

  // Window centered on row c of the current frame, padded above row 0 and below row H-1.
  function automatic win_t make_win(input int c, input int due);
    win_t w;
    logic [BUS-1:0] pad_t, pad_b;
`ifdef ROW_EDGE_REPLICATE_EN
    pad_t = row_vec(0);
    pad_b = row_vec(H-1);
`else
    pad_t = '0;
    pad_b = '0;
`endif
    w.top = (c == 0)   ? pad_t : row_vec(c-1);
    w.mid = row_vec(c);
    w.bot = (c == H-1) ? pad_b : row_vec(c+1);
    w.idx = c;
    w.fd  = (c == H-1);
    w.rdy = (c != H-2);
    w.due = due;
    return w;
  endfunction

  function automatic void model_accept(input logic [PW-1:0] p, input logic sof);
    if (sof && (mx != 0 || my != 0)) begin
      mx = 0;
      my = 0;
    end
    rows[my][mx] = p;
    if (mx == W-1) begin
      mx = 0;
      if (my >= 1) sb.push_back(make_win(my-1, ncyc+1));
      if (my == H-1) begin
        sb.push_back(make_win(H-1, ncyc+2));
        my = 0;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      ncyc++;
      if (row_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_row_valid", BUS'(row_valid), BUS'(0));
        end else begin
          mon_e = sb.pop_front();
          check("row_top",    row_top, mon_e.top);
          check("row_mid",    row_mid, mon_e.mid);
          check("row_bot",    row_bot, mon_e.bot);
          check("row_index",  BUS'(row_index), BUS'(mon_e.idx));
          check("frame_done", BUS'(frame_done), BUS'(mon_e.fd));
          check("pix_ready_at_window", BUS'(pix_ready), BUS'(mon_e.rdy));
          check("window_latency", BUS'(ncyc), BUS'(mon_e.due));
        end
      end else begin
        check("pix_ready_idle",  BUS'(pix_ready), BUS'(1));
        check("frame_done_idle", BUS'(frame_done), BUS'(0));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  task automatic send(input logic [PW-1:0] p, input logic sof);
    int n = 0;
    @(negedge clk);
    pix_in    = p;
    pix_sof   = sof;
    pix_valid = 1'b1;
    while (!pix_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) begin
      check("ready_timeout", BUS'(pix_ready), BUS'(1));
      pix_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(p, sof);
    end
  endtask

  // mode 0: pixel = 16*y+x, else random nonzero; gap 0: none, 1: toggle, 2: random 0..2.
  task automatic send_frame(input int mode, input int gap);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send((mode == 0) ? PW'(16*y + x) : PW'($urandom_range(1, 255)), (x == 0 && y == 0));
        if (gap == 1) idle(1);
        else if (gap == 2) idle($urandom_range(0, 2));
      end
    end
    idle(3);
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_ready",  BUS'(pix_ready), BUS'(1));
    check("rst_row_top",    row_top, '0);
    check("rst_row_mid",    row_mid, '0);
    check("rst_row_bot",    row_bot, '0);
    check("rst_row_valid",  BUS'(row_valid), BUS'(0));
    check("rst_frame_done", BUS'(frame_done), BUS'(0));
    check("rst_row_index",  BUS'(row_index), BUS'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pix_in    = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_outputs();
    idle(10);

    send_frame(0, 0);
    send_frame(0, 1);
    repeat (3) send_frame(1, 2);

    // Resync: sof arrives at (2,1); windows clear and the sof pixel starts a new frame.
    for (int k = 0; k < W + 2; k++) send(PW'($urandom_range(1, 255)), (k == 0));
    send(PW'($urandom_range(1, 255)), 1'b1);
    idle(1);
    #1;
    check("resync_top", row_top, '0);
    check("resync_mid", row_mid, '0);
    check("resync_bot", row_bot, '0);
    for (int k = 1; k < W*H; k++) send(PW'($urandom_range(1, 255)), 1'b0);
    idle(3);
    send_frame(1, 0);

    // Reset while the next pixel would be (1,2).
    for (int k = 0; k < 2*W + 1; k++) send(PW'($urandom_range(1, 255)), (k == 0));
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    sb.delete();
    mx = 0;
    my = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    send_frame(1, 2);
    send_frame(0, 0);

    idle(6);
    check("scoreboard_drained", BUS'(sb.size()), BUS'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
